mips_prog_loader: RTL and testbench
===================================

# mips_prog_loader

Byte-stream program loader that fills the MIPS32 unified memory's write port and then releases the multi-cycle controller. It accepts a length-prefixed big-endian byte stream over a valid/ready handshake and writes each assembled 32-bit word to consecutive word addresses starting at 0. When the image is complete it raises `cpu_start`, the level the controller samples to leave halt. It replaces hierarchical memory preloading in benches and is the boot path for hardware builds.

## Interface
- `ADDR_W`, 10: memory word-address width; maximum image is 2^ADDR_W words.
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load`  in  1  one-cycle pulse that starts a new load; ignored in LEN/DATA/CSUM.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  loader accepts a byte; a transfer occurs when `in_valid && in_ready`.
- `mem_we`  out  1  memory write strobe, one cycle per word.
- `mem_addr`  out  ADDR_W  word address of the write.
- `mem_wdata`  out  32  word being written.
- `cpu_start`  out  1  level to the controller `start`; high only in DONE.
- `busy`  out  1  high in LEN, DATA and CSUM.
- `error`  out  1  high in ERR.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: `in_ready`=0. `load` -> LEN.
- LEN: accept 4 bytes, MSB first, into a 32-bit count N.
  - N > 2^ADDR_W -> ERR.
  - N = 0 -> CSUM if the checksum is compiled in, else DONE.
  - Otherwise -> DATA.
- DATA: accept bytes MSB first. The 4th byte of word i issues a write with `mem_addr`=i. After word N-1 -> CSUM or DONE.
- CSUM: accept 4 bytes, compare with the running XOR of all data words. Equal -> DONE; otherwise -> ERR.
- DONE: `cpu_start`=1. `load` -> LEN; `cpu_start` drops in the same edge.
- ERR: `cpu_start`=0. Only `load` or `reset` leaves it; `load` -> LEN.
- Byte counter (2 bit) wraps 3->0 on each completed word. Word counter is ADDR_W+1 bits so N = 2^ADDR_W is representable.
- The XOR accumulator and word counter clear on entry to LEN.
- `load` while busy has no effect; the load in progress continues.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_start`=0, `busy`=0, `error`=0. State returns to IDLE.
- Reset mid-load abandons the image. No further writes occur; memory contents already written are left as they are.
- `in_ready` is registered: high from the cycle after entry to LEN through the cycle in which the last byte of LEN/DATA/CSUM is accepted. It is low in IDLE, DONE and ERR.
- Sustained rate is 1 byte per cycle, with no bubbles between words.
- Write latency: `mem_we`, `mem_addr` and `mem_wdata` are registered and valid the cycle after the 4th byte is accepted. `mem_we` is high for exactly one cycle.
- State transition timing:
  - The last-byte handshake edge moves the state to DONE/ERR.
  - `cpu_start`/`error` are high from that edge onward.
  - The final `mem_we` pulse coincides with the first `cpu_start` cycle; the controller's first fetch is at least one cycle later.
- If `in_valid` is low mid-word, the loader holds state and the partial word indefinitely. No timeout.

## Configuration
- `MIPS_LOADER_CHECKSUM_EN` defined:
  - CSUM state is present.
  - The stream carries a 4-byte trailer equal to the XOR of all N data words.
  - Mismatch -> ERR.
- Not defined:
  - CSUM state and the XOR accumulator are removed.
  - The stream is length plus data only.
  - DATA or zero-length LEN goes directly to DONE; ERR is reachable only via oversize N.

## Structure
- `mips_loader_pkg` holds:
  - the state enum;
  - `BYTES_PER_WORD` = 4;
  - the default `ADDR_W`.
- Sub-module `loader_word_asm` contains the byte shift register, the 2-bit byte counter and the `word_done` pulse. It is instantiated once and reused for the LEN, DATA and CSUM fields.

## Test plan
- Six-word add program:
  - Stimulus: N=6, then words 2801000a, 28020014, 28030019, 00222000, 00832800, fc000000, trailer d4a10807 when the checksum is enabled.
  - Required: six `mem_we` pulses at addresses 0..5 with those data, then `cpu_start`=1.
  - With the controller attached: R4=30, R5=55.
- Corrupt checksum: same image with trailer d4a10806 (macro on) -> `error`=1, `cpu_start` stays 0, and the six writes still occurred.
- Oversize length: ADDR_W=4, N=17 -> ERR after the 4th length byte, with zero `mem_we` pulses.
- N=0: `cpu_start` rises right after the length bytes (macro off), or after trailer 00000000 (macro on).
- Backpressure/gaps: `in_valid` toggled randomly within the six-word image -> identical writes and order. `in_ready` is never high in IDLE or DONE.
- Reset and reload:
  - `reset` asserted after 3 words -> all outputs 0 immediately and state IDLE; a fresh `load` plus full image completes normally.
  - `load` in DONE drops `cpu_start` the next cycle.

Source files
------------

// File: rtl/mips_loader_pkg.sv
// Shared definitions for the MIPS32 program loader: FSM states, word geometry
// and the default memory word-address width.
package mips_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int DEFAULT_ADDR_W = 10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } loader_state_e;

endpackage

// File: rtl/loader_word_asm.sv
// Big-endian byte-to-word assembler shared by the length, data and trailer fields.
// o_word/o_word_done are valid combinationally in the cycle the 4th byte is accepted.
import mips_loader_pkg::*;

module loader_word_asm (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_fire,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_byte_cnt;
  logic [23:0] r_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_byte_cnt <= 2'd0;
      r_shift    <= 24'd0;
    end else if (i_clear) begin
      r_byte_cnt <= 2'd0;
    end else if (i_fire) begin
      // Counter wraps 3->0 on its own, so each field starts on a fresh word.
      r_byte_cnt <= r_byte_cnt + 2'd1;
      r_shift    <= {r_shift[15:0], i_byte};
    end
  end

  assign o_word      = {r_shift, i_byte};
  assign o_word_done = i_fire && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mips_prog_loader.sv
// Length-prefixed byte-stream loader that fills unified memory and then raises cpu_start.
// Optional XOR trailer check is compiled in with MIPS_LOADER_CHECKSUM_EN.
import mips_loader_pkg::*;

module mips_prog_loader #(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_start,
  output logic              busy,
  output logic              error,
  output logic [2:0]        dbg_state
);

  // Stream handshake: a byte transfers on a rising edge where in_valid && in_ready;
  // in_ready is registered and never depends on in_valid.
  localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;

  loader_state_e     r_state;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_start;
  logic              r_busy;
  logic              r_error;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_word_cnt;
`ifdef MIPS_LOADER_CHECKSUM_EN
  logic [31:0]       r_xor;
`endif

  logic              w_fire;
  logic              w_start;
  logic [31:0]       w_word;
  logic              w_word_done;
  logic [ADDR_W:0]   w_word_cnt_nxt;

  assign w_fire         = in_valid && r_in_ready;
  assign w_start        = load && ((r_state == ST_IDLE) || (r_state == ST_DONE) || (r_state == ST_ERR));
  assign w_word_cnt_nxt = r_word_cnt + {{ADDR_W{1'b0}}, 1'b1};

  loader_word_asm u_word_asm (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_start),
    .i_fire      (w_fire),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_cpu_start <= 1'b0;
      r_busy      <= 1'b0;
      r_error     <= 1'b0;
      r_len       <= '0;
      r_word_cnt  <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
      r_xor       <= 32'd0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (load) begin
            r_state     <= ST_LEN;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_cpu_start <= 1'b0;
            r_error     <= 1'b0;
            r_word_cnt  <= '0;
`ifdef MIPS_LOADER_CHECKSUM_EN
            r_xor       <= 32'd0;
`endif
          end
        end
        ST_LEN: begin
          if (w_word_done) begin
            r_len <= w_word[ADDR_W:0];
            if ({1'b0, w_word} > MAX_WORDS) begin
              r_state    <= ST_ERR;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_error    <= 1'b1;
            end else if (w_word == 32'd0) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
              r_state     <= ST_CSUM;
`else
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_cpu_start <= 1'b1;
`endif
            end else begin
              r_state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (w_word_done) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
            r_mem_wdata <= w_word;
            r_word_cnt  <= w_word_cnt_nxt;
`ifdef MIPS_LOADER_CHECKSUM_EN
            r_xor       <= r_xor ^ w_word;
`endif
            if (w_word_cnt_nxt == r_len) begin
`ifdef MIPS_LOADER_CHECKSUM_EN
              r_state     <= ST_CSUM;
`else
              r_state     <= ST_DONE;
              r_in_ready  <= 1'b0;
              r_busy      <= 1'b0;
              r_cpu_start <= 1'b1;
`endif
            end
          end
        end
`ifdef MIPS_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (w_word_done) begin
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            if (w_word == r_xor) begin
              r_state     <= ST_DONE;
              r_cpu_start <= 1'b1;
            end else begin
              r_state <= ST_ERR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_start = r_cpu_start;
  assign busy      = r_busy;
  assign error     = r_error;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Bench for mips_prog_loader: drives length-prefixed images and scores memory writes
// against an image-level model (addresses 0..N-1, XOR trailer when compiled in).
module tb_mips_prog_loader;
  import mips_loader_pkg::*;

  localparam int ADDR_W = 4;
  localparam int MAXW   = 1 << ADDR_W;
  localparam int W      = ADDR_W + 32;

  logic              clk = 1'b0;
  logic              reset, load, in_valid;
  logic [7:0]        in_data;
  logic              in_ready, mem_we, cpu_start, busy, error;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [2:0]        dbg_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_e;
  logic [31:0]  img [0:31];
  int n_vec = 0, n_err = 0, n_writes = 0, n_rdy_viol = 0;
  bit g_gaps = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  mips_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .load(load), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_start(cpu_start), .busy(busy), .error(error), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (mem_we) begin
      n_writes++;
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %h, required no write", mem_addr, mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== mon_e) begin
          n_err++;
          $display("FAIL write: got addr %0d data %h, required addr %0d data %h",
                   mem_addr, mem_wdata, mon_e[W-1:32], mon_e[31:0]);
        end
      end
    end
    if (!reset && in_ready && (!busy || cpu_start || error)) n_rdy_viol++;
  end

  // ---------------- model ----------------
  function automatic logic [31:0] model_xor(input int n);
    logic [31:0] x = 32'd0;
    for (int i = 0; i < n; i++) x ^= img[i];
    return x;
  endfunction

  task automatic model_expect(input int n);
    if (n <= MAXW)
      for (int i = 0; i < n; i++) exp_q.push_back({i[ADDR_W-1:0], img[i]});
  endtask

  // ---------------- drivers ----------------
  task automatic send_byte(input logic [7:0] b);
    int cnt = 0;
    if (g_gaps) begin
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      cnt++;
      if (cnt > 100) begin
        n_vec++; n_err++;
        $display("FAIL byte_timeout: got in_ready 0 for %0d cycles, required 1", cnt);
        in_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[k*8 +: 8]);
  endtask

  task automatic pulse_load();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic send_image(input logic [31:0] n, input logic [31:0] trailer);
    send_word(n);
    if (n <= MAXW) begin
      for (int i = 0; i < int'(n); i++) send_word(img[i]);
`ifdef MIPS_LOADER_CHECKSUM_EN
      send_word(trailer);
`endif
    end
  endtask

  task automatic load_add_program();
    img[0] = 32'h2801000a; img[1] = 32'h28020014; img[2] = 32'h28030019;
    img[3] = 32'h00222000; img[4] = 32'h00832800; img[5] = 32'hfc000000;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk); #1;
    n_vec += 8;
    if (in_ready  !== 1'b0) begin n_err++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    if (mem_we    !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b, required 0", mem_we); end
    if (mem_addr  !== '0)   begin n_err++; $display("FAIL reset_mem_addr: got %0d, required 0", mem_addr); end
    if (mem_wdata !== 32'd0) begin n_err++; $display("FAIL reset_mem_wdata: got %h, required 0", mem_wdata); end
    if (cpu_start !== 1'b0) begin n_err++; $display("FAIL reset_cpu_start: got %b, required 0", cpu_start); end
    if (busy      !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b, required 0", busy); end
    if (error     !== 1'b0) begin n_err++; $display("FAIL reset_error: got %b, required 0", error); end
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_six_word();
    load_add_program();
    model_expect(6);
    pulse_load();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL six_busy: got %b, required 1", busy); end
    send_image(6, 32'hd4a10807);
    n_vec += 4;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL six_cpu_start: got %b, required 1", cpu_start); end
    if (error !== 1'b0) begin n_err++; $display("FAIL six_error: got %b, required 0", error); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL six_busy_done: got %b, required 0", busy); end
`ifndef MIPS_LOADER_CHECKSUM_EN
    if (mem_we !== 1'b1) begin n_err++; $display("FAIL six_last_we_with_start: got %b, required 1", mem_we); end
`else
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL six_we_after_trailer: got %b, required 0", mem_we); end
`endif
    @(posedge clk); #1;
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL six_writes_left: got %0d pending, required 0", exp_q.size()); end
  endtask

  task automatic test_load_in_done();
    load = 1'b1;
    n_vec++;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL done_before_load: got %b, required 1", cpu_start); end
    @(posedge clk); #1;
    load = 1'b0;
    n_vec += 2;
    if (cpu_start !== 1'b0) begin n_err++; $display("FAIL done_reload_start: got %b, required 0", cpu_start); end
    if (busy !== 1'b1) begin n_err++; $display("FAIL done_reload_busy: got %b, required 1", busy); end
    model_expect(6);
    send_image(6, model_xor(6));
    @(posedge clk); #1;
    n_vec += 2;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL reload_cpu_start: got %b, required 1", cpu_start); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL reload_writes_left: got %0d, required 0", exp_q.size()); end
  endtask

`ifdef MIPS_LOADER_CHECKSUM_EN
  task automatic test_corrupt_csum();
    int w0 = n_writes;
    load_add_program();
    model_expect(6);
    pulse_load();
    send_image(6, 32'hd4a10806);
    @(posedge clk); #1;
    n_vec += 3;
    if (error !== 1'b1) begin n_err++; $display("FAIL csum_error: got %b, required 1", error); end
    if (cpu_start !== 1'b0) begin n_err++; $display("FAIL csum_cpu_start: got %b, required 0", cpu_start); end
    if (n_writes - w0 != 6) begin n_err++; $display("FAIL csum_write_count: got %0d, required 6", n_writes - w0); end
  endtask
`endif

  task automatic test_oversize();
    int w0 = n_writes;
    pulse_load();
    send_image(MAXW + 1, 32'd0);
    repeat (2) @(posedge clk); #1;
    n_vec += 4;
    if (error !== 1'b1) begin n_err++; $display("FAIL over_error: got %b, required 1", error); end
    if (cpu_start !== 1'b0) begin n_err++; $display("FAIL over_cpu_start: got %b, required 0", cpu_start); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL over_busy: got %b, required 0", busy); end
    if (n_writes != w0) begin n_err++; $display("FAIL over_writes: got %0d, required 0", n_writes - w0); end
    // Largest legal image fills every address.
    for (int i = 0; i < MAXW; i++) img[i] = $urandom;
    model_expect(MAXW);
    pulse_load();
    n_vec++;
    if (error !== 1'b0) begin n_err++; $display("FAIL max_error_clear: got %b, required 0", error); end
    send_image(MAXW, model_xor(MAXW));
    @(posedge clk); #1;
    n_vec += 2;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL max_cpu_start: got %b, required 1", cpu_start); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL max_writes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_zero_len();
    int w0 = n_writes;
    pulse_load();
    send_image(0, 32'd0);
    n_vec += 3;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL zero_cpu_start: got %b, required 1", cpu_start); end
    if (error !== 1'b0) begin n_err++; $display("FAIL zero_error: got %b, required 0", error); end
    if (n_writes != w0) begin n_err++; $display("FAIL zero_writes: got %0d, required 0", n_writes - w0); end
  endtask

  task automatic test_random_gaps();
    int n;
    g_gaps = 1'b1;
    for (int it = 0; it < 5; it++) begin
      if (it == 0) begin
        n = 6;
        load_add_program();
      end else begin
        n = $urandom_range(1, MAXW);
        for (int i = 0; i < n; i++) img[i] = $urandom;
      end
      model_expect(n);
      pulse_load();
      send_image(n, model_xor(n));
      @(posedge clk); #1;
      n_vec += 2;
      if (cpu_start !== 1'b1) begin n_err++; $display("FAIL gaps_cpu_start[%0d]: got %b, required 1", it, cpu_start); end
      if (exp_q.size() != 0) begin n_err++; $display("FAIL gaps_writes_left[%0d]: got %0d, required 0", it, exp_q.size()); end
    end
    g_gaps = 1'b0;
  endtask

  task automatic test_load_while_busy();
    for (int i = 0; i < 6; i++) img[i] = $urandom;
    model_expect(6);
    pulse_load();
    send_word(32'd6);
    send_word(img[0]);
    send_byte(img[1][31:24]);
    send_byte(img[1][23:16]);
    pulse_load();
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL busy_load_ignored: got busy %b, required 1", busy); end
    send_byte(img[1][15:8]);
    send_byte(img[1][7:0]);
    for (int i = 2; i < 6; i++) send_word(img[i]);
`ifdef MIPS_LOADER_CHECKSUM_EN
    send_word(model_xor(6));
`endif
    @(posedge clk); #1;
    n_vec += 2;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL busy_cpu_start: got %b, required 1", cpu_start); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL busy_writes_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_reset_midload();
    int w0;
    load_add_program();
    model_expect(6);
    pulse_load();
    send_word(32'd6);
    for (int i = 0; i < 3; i++) send_word(img[i]);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_vec += 6;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL mid_in_ready: got %b, required 0", in_ready); end
    if (mem_we !== 1'b0) begin n_err++; $display("FAIL mid_mem_we: got %b, required 0", mem_we); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b, required 0", busy); end
    if (cpu_start !== 1'b0 || error !== 1'b0) begin n_err++; $display("FAIL mid_flags: got start %b err %b, required 0 0", cpu_start, error); end
    if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL mid_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    if (exp_q.size() != 3) begin n_err++; $display("FAIL mid_write_count: got %0d pending, required 3", exp_q.size()); end
    exp_q.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    w0 = n_writes;
    repeat (4) @(posedge clk); #1;
    n_vec++;
    if (n_writes != w0) begin n_err++; $display("FAIL mid_stray_writes: got %0d, required 0", n_writes - w0); end
    model_expect(6);
    pulse_load();
    send_image(6, model_xor(6));
    @(posedge clk); #1;
    n_vec += 2;
    if (cpu_start !== 1'b1) begin n_err++; $display("FAIL mid_reload_start: got %b, required 1", cpu_start); end
    if (exp_q.size() != 0) begin n_err++; $display("FAIL mid_reload_left: got %0d, required 0", exp_q.size()); end
  endtask

  task automatic test_ready_invariant();
    n_vec++;
    if (n_rdy_viol != 0) begin n_err++; $display("FAIL ready_when_idle: got %0d cycles, required 0", n_rdy_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_six_word();
    test_load_in_done();
`ifdef MIPS_LOADER_CHECKSUM_EN
    test_corrupt_csum();
`endif
    test_oversize();
    test_zero_len();
    test_random_gaps();
    test_load_while_busy();
    test_reset_midload();
    test_ready_invariant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_vec++; n_err++;
    $display("FAIL watchdog: got no completion by 200000 ns, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
